// File: rtl/spi_cmd_master.sv
// spi_cmd_master: serialises write-FIFO command entries as SPI mode-0 frames and pushes read responses
module spi_cmd_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [40:0] DATA_from_WriteFIFO,
    output logic        WriteFIFO_rd_en,
    input  logic        WriteFIFO_empty,
    output logic [31:0] DATA_to_ReadFIFO,
    output logic        ReadFIFO_wr_en,
    input  logic        ReadFIFO_full,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SS_n,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, SETUP, SHIFT, HOLD, PUSH} state_t;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    state_t      state_q, state_d;
    logic [40:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic        rw_q, rw_d, sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d, rd_en_q, rd_en_d;
    logic        phase_end;
    assign WriteFIFO_rd_en  = rd_en_q;
    assign DATA_to_ReadFIFO = rx_q;
    assign ReadFIFO_wr_en   = state_q == PUSH && !ReadFIFO_full;
    assign SCLK             = sclk_q;
    assign MOSI             = mosi_q;
    assign SS_n             = ss_n_q;
    assign busy             = state_q != IDLE;
    // next-state: SETUP, each SCLK phase and HOLD all last CLK_DIV cycles; SHIFT starts with a low phase
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        rw_d      = rw_q;
        sclk_d    = sclk_q;
        phase_end = div_q == DIV_LAST;
        case (state_q)
            IDLE: if (!WriteFIFO_empty) state_d = POP;
            POP: state_d = LOAD;
            LOAD: begin
                tx_d    = DATA_from_WriteFIFO;
                rw_d    = DATA_from_WriteFIFO[40];
                rx_d    = '0;
                cnt_d   = '0;
                div_d   = '0;
                sclk_d  = 1'b0;
                state_d = SETUP;
            end
            SETUP: begin
                div_d = phase_end ? 8'd0 : div_q + 8'd1;
                if (phase_end) state_d = SHIFT;
            end
            SHIFT: begin
                div_d = phase_end ? 8'd0 : div_q + 8'd1;
                if (phase_end) begin
                    sclk_d = !sclk_q;
                    if (!sclk_q) rx_d = {rx_q[30:0], MISO};
                    else begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q < 6'd40) tx_d = {tx_q[39:0], 1'b0};
                        else state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                div_d = phase_end ? 8'd0 : div_q + 8'd1;
                if (phase_end) state_d = rw_q ? IDLE : PUSH;
            end
            PUSH: if (!ReadFIFO_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ss_n_d  = !(state_d inside {SETUP, SHIFT, HOLD});
        mosi_d  = !ss_n_d && tx_d[40];
        rd_en_d = state_d == POP;
    end
    // state and SPI pin registers; reset aborts any frame in flight
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rw_q    <= rw_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            rd_en_q <= rd_en_d;
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed tests with FIFO and SPI slave models around two divider settings
module tb_spi_cmd_master;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [40:0] wdata = '0;
    logic wempty = 1'b1, rfull = 1'b0, miso = 1'b0, sel = 1'b0;
    logic e1, e2, rd1, wr1, sclk1, mosi1, ss1, busy1, rd2, wr2, sclk2, mosi2, ss2, busy2;
    logic [31:0] rdat1, rdat2, m_dat;
    logic m_rd, m_wr, m_sclk, m_mosi, m_ss, m_busy;
    int checks = 0, errors = 0;
    int cyc = 0, frames = 0, pulses = 0, low_cnt = 0, high_cnt = 0, busy_low = 0, rd_pulses = 0, pushes = 0;
    int last_rise = 0, per_min = 0, per_max = 0, hi_cnt = 0, fall_cyc = 0, mosi_bad = 0;
    int f_low = 0, f_pulses = 0, f_permin = 0, f_permax = 0, f_hi = 0;
    logic prev_sclk = 1'b0, prev_ss = 1'b1;
    logic [40:0] bit_sh = '0, s_sh = '0, f_bits = '0;
    logic [40:0] wq[$], sq[$], fq[$];
    logic [31:0] rq[$];
    int gapq[$], bq[$];

    always #5 HCLK = ~HCLK;

    assign e1 = wempty | sel;
    assign e2 = wempty | ~sel;
    assign m_rd = sel ? rd2 : rd1;
    assign m_wr = sel ? wr2 : wr1;
    assign m_sclk = sel ? sclk2 : sclk1;
    assign m_mosi = sel ? mosi2 : mosi1;
    assign m_ss = sel ? ss2 : ss1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_dat = sel ? rdat2 : rdat1;

    spi_cmd_master #(.CLK_DIV(4)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .DATA_from_WriteFIFO(wdata),
        .WriteFIFO_rd_en(rd1), .WriteFIFO_empty(e1), .DATA_to_ReadFIFO(rdat1), .ReadFIFO_wr_en(wr1),
        .ReadFIFO_full(rfull), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso), .SS_n(ss1), .busy(busy1));
    spi_cmd_master #(.CLK_DIV(2)) dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .DATA_from_WriteFIFO(wdata),
        .WriteFIFO_rd_en(rd2), .WriteFIFO_empty(e2), .DATA_to_ReadFIFO(rdat2), .ReadFIFO_wr_en(wr2),
        .ReadFIFO_full(rfull), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso), .SS_n(ss2), .busy(busy2));

    // FIFO models, SPI slave and frame monitor, all sampled on the falling HCLK edge
    always @(negedge HCLK) begin
        cyc++;
        if (m_rd) begin
            rd_pulses++;
            if (wq.size() > 0) wdata = wq.pop_front();
            wempty = (wq.size() == 0);
        end
        if (m_wr) begin
            pushes++;
            rq.push_back(m_dat);
        end
        if (!m_ss) begin
            if (prev_ss) begin
                fall_cyc = cyc;
                gapq.push_back(high_cnt);
                bq.push_back(busy_low);
                low_cnt = 0;
                pulses = 0;
                hi_cnt = 0;
                bit_sh = '0;
                per_min = 1000;
                per_max = 0;
                if (sq.size() > 0) s_sh = sq.pop_front();
                else s_sh = '0;
                miso = s_sh[40];
            end
            low_cnt++;
            if (m_sclk) hi_cnt++;
            if (m_sclk && !prev_sclk) begin
                bit_sh = {bit_sh[39:0], m_mosi};
                if (pulses > 0) begin
                    if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                end
                last_rise = cyc;
                pulses++;
            end
            if (!m_sclk && prev_sclk) begin
                s_sh = {s_sh[39:0], 1'b0};
                miso = s_sh[40];
            end
        end else begin
            if (!prev_ss) begin
                frames++;
                fq.push_back(bit_sh);
                f_bits = bit_sh;
                f_low = low_cnt;
                f_pulses = pulses;
                f_permin = per_min;
                f_permax = per_max;
                f_hi = hi_cnt;
                high_cnt = 0;
                busy_low = 0;
            end
            high_cnt++;
            if (!m_busy) busy_low++;
            if (m_mosi || m_sclk) mosi_bad++;
        end
        prev_ss = m_ss;
        prev_sclk = m_sclk;
    end

    // global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [40:0] e);
        wq.push_back(e);
        wempty = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string what);
        int k = 0;
        while (frames < n && k < budget) begin
            @(negedge HCLK);
            #1;
            k++;
        end
        checks++;
        if (frames < n) begin errors++; $display("FAIL %s_timeout frames got %0d exp %0d", what, frames, n); end
    endtask

    task automatic settle();
        repeat (10) begin
            @(negedge HCLK);
            #1;
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        #1;
        checks++; if (ss1 !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b exp 1", ss1); end
        checks++; if (sclk1 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk1); end
        checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi1); end
        checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd1); end
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr1); end
        checks++; if (rdat1 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdat1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
        checks++; if (ss2 !== 1'b1) begin errors++; $display("FAIL reset_ss_n_div2 got %b exp 1", ss2); end
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
    endtask

    task automatic test_write();
        int n, t0;
        sel = 1'b0;
        rd_pulses = 0;
        pushes = 0;
        mosi_bad = 0;
        n = frames;
        push(41'h1_55_DEADBEEF);
        t0 = cyc;
        wait_frames(n + 1, 2000, "write");
        settle();
        checks++; if (fall_cyc - t0 !== 3) begin errors++; $display("FAIL write_latency got %0d exp 3", fall_cyc - t0); end
        checks++; if (rd_pulses !== 1) begin errors++; $display("FAIL write_rd_en got %0d exp 1", rd_pulses); end
        checks++; if (f_low !== 336) begin errors++; $display("FAIL write_ss_low got %0d exp 336", f_low); end
        checks++; if (f_pulses !== 41) begin errors++; $display("FAIL write_pulses got %0d exp 41", f_pulses); end
        checks++; if (f_bits !== 41'h1_55_DEADBEEF) begin errors++; $display("FAIL write_mosi got %h exp 155deadbeef", f_bits); end
        checks++; if (f_permin !== 8 || f_permax !== 8) begin errors++; $display("FAIL write_period got %0d..%0d exp 8", f_permin, f_permax); end
        checks++; if (f_hi !== 164) begin errors++; $display("FAIL write_high_time got %0d exp 164", f_hi); end
        checks++; if (pushes !== 0) begin errors++; $display("FAIL write_wr_en got %0d exp 0", pushes); end
        checks++; if (mosi_bad !== 0) begin errors++; $display("FAIL write_idle_pins got %0d exp 0", mosi_bad); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL write_busy_after got %b exp 0", busy1); end
    endtask

    task automatic test_read();
        int n;
        rd_pulses = 0;
        pushes = 0;
        fq.delete();
        rq.delete();
        gapq.delete();
        n = frames;
        sq.push_back({9'h16B, 32'h12345678});
        sq.push_back({9'h0F0, 32'h9ABC0123});
        push(41'h0_A3_00000000);
        push(41'h0_5A_00000000);
        wait_frames(n + 2, 3000, "read");
        settle();
        checks++; if (fq.size() !== 2 || fq[0] !== 41'h0_A3_00000000) begin errors++; $display("FAIL read_mosi got %h exp 0a300000000", fq[0]); end
        checks++; if (fq[1] !== 41'h0_5A_00000000) begin errors++; $display("FAIL read2_mosi got %h exp 05a00000000", fq[1]); end
        checks++; if (pushes !== 2) begin errors++; $display("FAIL read_pushes got %0d exp 2", pushes); end
        checks++; if (rq[0] !== 32'h12345678) begin errors++; $display("FAIL read_data got %h exp 12345678", rq[0]); end
        checks++; if (rq[1] !== 32'h9ABC0123) begin errors++; $display("FAIL read2_data got %h exp 9abc0123", rq[1]); end
        checks++; if (gapq[1] !== 4) begin errors++; $display("FAIL read_gap got %0d exp 4", gapq[1]); end
        checks++; if (rd_pulses !== 2) begin errors++; $display("FAIL read_rd_en got %0d exp 2", rd_pulses); end
    endtask

    task automatic test_read_full();
        int n, bad;
        rd_pulses = 0;
        pushes = 0;
        bad = 0;
        fq.delete();
        rq.delete();
        gapq.delete();
        rfull = 1'b1;
        n = frames;
        sq.push_back({9'h0AA, 32'hCAFEF00D});
        sq.push_back('0);
        push(41'h0_3C_00000000);
        push(41'h1_E7_13579BDF);
        wait_frames(n + 1, 2000, "full");
        for (int i = 0; i < 20; i++) begin
            if (ss1 !== 1'b1 || wr1 !== 1'b0 || busy1 !== 1'b1 || rd_pulses !== 1) bad++;
            @(negedge HCLK);
            #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_stall got %0d bad cycles exp 0", bad); end
        @(posedge HCLK);
        #1;
        rfull = 1'b0;
        #1;
        checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL full_release_wr_en got %b exp 1", wr1); end
        checks++; if (rdat1 !== 32'hCAFEF00D) begin errors++; $display("FAIL full_held_data got %h exp cafef00d", rdat1); end
        wait_frames(n + 2, 2000, "full_next");
        settle();
        checks++; if (pushes !== 1 || rq[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL full_push got %0d x %h exp 1 x cafef00d", pushes, rq[0]); end
        checks++; if (gapq[gapq.size()-1] !== 25) begin errors++; $display("FAIL full_gap got %0d exp 25", gapq[gapq.size()-1]); end
        checks++; if (fq[fq.size()-1] !== 41'h1_E7_13579BDF) begin errors++; $display("FAIL full_next_mosi got %h exp 1e713579bdf", fq[fq.size()-1]); end
        checks++; if (rd_pulses !== 2) begin errors++; $display("FAIL full_rd_en got %0d exp 2", rd_pulses); end
    endtask

    task automatic test_back_to_back();
        int n;
        rd_pulses = 0;
        pushes = 0;
        fq.delete();
        gapq.delete();
        bq.delete();
        n = frames;
        push(41'h1_01_11111111);
        push(41'h1_80_22222222);
        push(41'h1_FE_00000001);
        wait_frames(n + 3, 4000, "b2b");
        settle();
        checks++; if (fq.size() !== 3) begin errors++; $display("FAIL b2b_frames got %0d exp 3", fq.size()); end
        checks++; if (fq[0] !== 41'h1_01_11111111) begin errors++; $display("FAIL b2b_frame0 got %h exp 10111111111", fq[0]); end
        checks++; if (fq[1] !== 41'h1_80_22222222) begin errors++; $display("FAIL b2b_frame1 got %h exp 18022222222", fq[1]); end
        checks++; if (fq[2] !== 41'h1_FE_00000001) begin errors++; $display("FAIL b2b_frame2 got %h exp 1fe00000001", fq[2]); end
        checks++; if (gapq[1] !== 3 || gapq[2] !== 3) begin errors++; $display("FAIL b2b_gap got %0d,%0d exp 3,3", gapq[1], gapq[2]); end
        checks++; if (bq[1] !== 1 || bq[2] !== 1) begin errors++; $display("FAIL b2b_busy_low got %0d,%0d exp 1,1", bq[1], bq[2]); end
        checks++; if (rd_pulses !== 3 || pushes !== 0) begin errors++; $display("FAIL b2b_strobes got rd %0d wr %0d exp 3 0", rd_pulses, pushes); end
    endtask

    task automatic test_reset_mid();
        int n, k;
        rd_pulses = 0;
        pushes = 0;
        k = 0;
        n = frames;
        sq.push_back(41'h1FF_FFFFFFFF);
        sq.push_back('0);
        push(41'h0_C3_00000000);
        push(41'h1_3C_A5A5A5A5);
        while (!(m_ss === 1'b0 && pulses >= 20) && k < 2000) begin
            @(negedge HCLK);
            #1;
            k++;
        end
        checks++; if (pulses !== 20) begin errors++; $display("FAIL mid_reach_pulse20 got %0d exp 20", pulses); end
        HRESETn = 1'b0;
        @(negedge HCLK);
        #1;
        checks++; if (ss1 !== 1'b1 || sclk1 !== 1'b0 || mosi1 !== 1'b0) begin errors++; $display("FAIL mid_reset_pins got ss %b sclk %b mosi %b exp 1 0 0", ss1, sclk1, mosi1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy1); end
        repeat (2) @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
        wait_frames(n + 2, 2000, "mid");
        settle();
        checks++; if (f_bits !== 41'h1_3C_A5A5A5A5) begin errors++; $display("FAIL mid_next_mosi got %h exp 13ca5a5a5a5", f_bits); end
        checks++; if (f_low !== 336 || f_pulses !== 41) begin errors++; $display("FAIL mid_next_frame got %0d cycles %0d pulses exp 336 41", f_low, f_pulses); end
        checks++; if (pushes !== 0) begin errors++; $display("FAIL mid_push got %0d exp 0", pushes); end
        checks++; if (rd_pulses !== 2) begin errors++; $display("FAIL mid_rd_en got %0d exp 2", rd_pulses); end
    endtask

    task automatic test_idle_div2();
        int n, t0, bad;
        sel = 1'b1;
        rd_pulses = 0;
        pushes = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (ss2 !== 1'b1 || rd2 !== 1'b0) bad++;
            @(negedge HCLK);
            #1;
        end
        checks++; if (bad !== 0 || rd_pulses !== 0) begin errors++; $display("FAIL idle_quiet got %0d bad %0d pops exp 0 0", bad, rd_pulses); end
        n = frames;
        push(41'h1_96_89ABCDEF);
        t0 = cyc;
        wait_frames(n + 1, 1000, "div2");
        settle();
        checks++; if (fall_cyc - t0 !== 3) begin errors++; $display("FAIL div2_latency got %0d exp 3", fall_cyc - t0); end
        checks++; if (f_low !== 168) begin errors++; $display("FAIL div2_ss_low got %0d exp 168", f_low); end
        checks++; if (f_permin !== 4 || f_permax !== 4) begin errors++; $display("FAIL div2_period got %0d..%0d exp 4", f_permin, f_permax); end
        checks++; if (f_hi !== 82 || f_pulses !== 41) begin errors++; $display("FAIL div2_pulses got %0d high %0d pulses exp 82 41", f_hi, f_pulses); end
        checks++; if (f_bits !== 41'h1_96_89ABCDEF) begin errors++; $display("FAIL div2_mosi got %h exp 19689abcdef", f_bits); end
        checks++; if (rd_pulses !== 1 || pushes !== 0) begin errors++; $display("FAIL div2_strobes got rd %0d wr %0d exp 1 0", rd_pulses, pushes); end
    endtask

    initial begin
        @(negedge HCLK);
        #1;
        test_reset();
        test_write();
        test_read();
        test_read_full();
        test_back_to_back();
        test_reset_mid();
        test_idle_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
